// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two clients share one ALU.
// Operands sit in stage S1, the ALU runs combinationally from S1, and S2 holds the response.

module ALU #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             less_than
);

  always_comb begin
    less_than = $signed(a) < $signed(b);
    case (control)
      3'd0:    out = a + b;
      3'd1:    out = a - b;
      3'd2:    out = a & b;
      3'd3:    out = a | b;
      3'd4:    out = a ^ b;
      3'd5:    out = {{(WIDTH-1){1'b0}}, less_than};
      3'd6:    out = ~(a | b);
      default: out = '0;
    endcase
    zero = (out == '0);
  end

endmodule

module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_lt,
  output logic             resp_err,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_id;
  logic             last;

  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_lt;

  logic             resp_fire;
  logic             s2_load;
  logic             s1_free;
  logic             grant;
  logic             accept;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_b;
  logic [2:0]       acc_op;

  ALU #(.WIDTH(WIDTH)) u_alu (
    .a         (s1_a),
    .b         (s1_b),
    .control   (s1_op),
    .out       (alu_out),
    .zero      (alu_zero),
    .less_than (alu_lt)
  );

  assign resp_fire = resp_valid & resp_ready;
  assign s2_load   = s1_valid & (~resp_valid | resp_ready);
  assign s1_free   = ~s1_valid | s2_load;

  // Under contention the requester that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = rst_n & s1_free & ~grant;
  assign req1_ready = rst_n & s1_free & grant;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign acc_a  = grant ? req1_a  : req0_a;
  assign acc_b  = grant ? req1_b  : req0_b;
  assign acc_op = grant ? req1_op : req0_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_id    <= 1'b0;
      last     <= 1'b1;
    end else begin
      if (s1_free) s1_valid <= accept;
      if (accept) begin
        s1_a  <= acc_a;
        s1_b  <= acc_b;
        s1_op <= acc_op;
        s1_id <= grant;
        last  <= grant;
      end
    end
  end

  // Opcode 7 is reported as an error with all ALU flags forced low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_lt     <= 1'b0;
      resp_err    <= 1'b0;
      op_count    <= '0;
    end else begin
      if (s2_load) begin
        resp_valid <= 1'b1;
        resp_id    <= s1_id;
        if (s1_op == 3'd7) begin
          resp_result <= '0;
          resp_zero   <= 1'b0;
          resp_lt     <= 1'b0;
          resp_err    <= 1'b1;
        end else begin
          resp_result <= alu_out;
          resp_zero   <= alu_zero;
          resp_lt     <= alu_lt;
          resp_err    <= 1'b0;
        end
      end else if (resp_fire) begin
        resp_valid <= 1'b0;
      end
      if (resp_fire) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and two-stage pipeline wrapper around the shared `ALU` (A, B, 3-bit control -> out, Zero, LessThan). It lets two independent clients (e.g. the main datapath and a branch/address unit) share one ALU instance through valid/ready handshakes. Every accepted operation returns exactly one response tagged with its requester ID, and responses come back in acceptance order.

## Interface
- `WIDTH`, 32: operand/result width; must equal the `ALU` width.
- `CNT_W`, 16: width of the completed-operation counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle when high together with `req0_valid`.
- `req0_a`, `req0_b` in WIDTH: signed operands.
- `req0_op` in 3: ALU control code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0.
- `resp_valid` out 1: response held on the outputs.
- `resp_ready` in 1: consumer takes the response.
- `resp_id` out 1: requester that issued the operation.
- `resp_result` out WIDTH: `ALU` out.
- `resp_zero`, `resp_lt` out 1: `ALU` Zero / LessThan.
- `resp_err` out 1: illegal opcode (3'd7).
- `op_count` out CNT_W: number of responses consumed.

## Operation
- Pipeline stages:
  - S1 holds operands, opcode, ID and a valid bit.
  - The `ALU` is combinational from the S1 registers.
  - S2 is the response register.
- Advance rules:
  - S2 loads when S1 is valid and either S2 is empty or S2 is handshaking (`resp_valid & resp_ready`).
  - S1 accepts when it is empty or advancing this cycle.
- Arbitration:
  - `reqN_ready` = S1-can-accept & grant==N. At most one ready is high per cycle.
  - A `last` register holds the ID of the last accepted request.
  - Both requesters valid: grant !`last`. One valid: grant it.
  - `last` updates only on an actual handshake.
  - Ready for the non-granted requester is 0. Ready does not depend on the requester's own data, only on valid bits and pipeline state.
- Illegal op 7:
  - Accepted normally.
  - Response has `resp_err`=1, `resp_result`=0, `resp_zero`=0, `resp_lt`=0. `ALU` outputs are ignored.
- Ops 0–6 pass through to `ALU` unmodified; `resp_err`=0.
- `op_count` increments on each `resp_valid & resp_ready` and wraps from 2^CNT_W-1 to 0.
- Response outputs are stable while `resp_valid & !resp_ready`.
- Requester inputs may change freely when not handshaking.

## Timing
- Reset (async assert, released synchronously with `clk`):
  - S1/S2 valid=0 and `last`=1, so requester 0 wins the first contention.
  - `op_count`=0; `resp_valid`=0; `resp_id`/`resp_result`/`resp_zero`/`resp_lt`/`resp_err` = 0.
  - Ready outputs are 0 while `rst_n`=0.
- Reset mid-operation discards everything in flight; no response is produced for it.
- Latency: a request accepted at edge T produces `resp_valid`=1 after edge T+1, provided S2 was free or draining.
- Throughput: 1 operation/cycle with `resp_ready` held high, alternating requesters under full contention.
- Backpressure: with `resp_ready`=0, S2 holds, then S1 holds, then both readies drop after at most 2 accepted operations.
- Simultaneous S2 drain and S1 load in one cycle is legal and loses no bubble.
- Ordering: responses leave strictly in acceptance order.

## Test plan
- Reset, then req0 only (a=31, b=5, op=0), `resp_ready`=1:
  - `req0_ready`=1 in the same cycle.
  - `resp_valid` 2 edges later with `resp_id`=0.
  - result/zero/lt equal to a bench `ALU` instance fed (31, 5, 0).
  - `op_count`=1.
- Both requesters valid for 6 cycles with ops 1..6 and distinct operands:
  - Grants go 0,1,0,1,0,1.
  - Six responses arrive back-to-back with matching IDs and `ALU`-model values.
- `resp_ready`=0 for 5 cycles with both requesters valid:
  - Exactly 2 handshakes, then readies stay 0.
  - `resp_*` stable throughout.
  - After `resp_ready`=1, both held responses drain in order with no loss or duplication.
- req1 op=7 (a=27, b=27) -> `resp_err`=1, `resp_result`=0, `resp_zero`=0, `resp_lt`=0, `resp_id`=1. Next op=2 from req1 -> `resp_err`=0.
- Assert `rst_n`=0 asynchronously while S1 and S2 are full:
  - All outputs return to reset values immediately.
  - No stale response after release.
  - First contention is granted to requester 0.
- CNT_W=4 build, 17 consumed responses -> `op_count` reads 1 (wrapped through 15 -> 0).
